// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller
//   Owns the program counter and sequences a synchronous instruction memory
//   (one-cycle read latency). Each returned word is tagged with the PC it
//   came from and placed into a small fetch queue. The queue head is offered
//   to decode through a valid/ready handshake. Start/Halt control fetching;
//   a redirect reloads the PC and flushes everything that is stale.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | after reset, no fetches issued; waiting for Start
//   FETCH  | issuing sequential fetches while queue credit is available
//   HALTED | no new fetches; in-flight response lands, queue keeps draining
//
// Ports
//   Clock, ResetN            clock, synchronous active-low reset
//   Start, Halt              run control (Halt wins over Start)
//   RedirectValid/Target     load PC (word aligned) and flush
//   MemReadEnable            read request this cycle
//   InstructionAddress       read address, always the current PC
//   Instruction              read data, one cycle after MemReadEnable
//   FetchValid/Instruction/PC  queue head towards decode (zero when empty)
//   FetchReady               decode accepts the head this cycle
//   Running                  state is FETCH
module instruction_fetch_controller #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Start,
    input  logic                  Halt,
    input  logic                  RedirectValid,
    input  logic [ADDR_WIDTH-1:0] RedirectTarget,
    output logic                  MemReadEnable,
    output logic [ADDR_WIDTH-1:0] InstructionAddress,
    input  logic [31:0]           Instruction,
    output logic                  FetchValid,
    output logic [31:0]           FetchInstruction,
    output logic [ADDR_WIDTH-1:0] FetchPC,
    input  logic                  FetchReady,
    output logic                  Running
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;

    logic [31:0]           q_instr [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        credit_used;
    logic [CNT_W:0]        credit_limit;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start && !Halt) state_next = FETCH;
            FETCH:   if (Halt)           state_next = HALTED;
            HALTED:  if (Start && !Halt) state_next = FETCH;
            default:                     state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_next;
    end

    assign FetchValid = (count != '0);
    assign pop        = FetchValid && FetchReady;

    // A slot being popped this cycle is free again by the time a fetch issued
    // now returns, so it counts as credit. Without it a two-entry queue could
    // only sustain one instruction every other cycle.
    assign credit_used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign credit_limit = (CNT_W+1)'(QUEUE_DEPTH) + {{CNT_W{1'b0}}, pop};

    assign issue = (state == FETCH) && !RedirectValid && (credit_used < credit_limit);

    // A response arriving in a redirect cycle belongs to the old stream.
    assign push  = inflight && !RedirectValid;

    assign MemReadEnable      = issue;
    assign InstructionAddress = pc;
    assign Running            = (state == FETCH);

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (RedirectValid)
                pc <= {RedirectTarget[ADDR_WIDTH-1:2], 2'b00};
            else if (issue)
                pc <= pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN || RedirectValid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            q_instr[wr_ptr] <= Instruction;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

    assign FetchInstruction = FetchValid ? q_instr[rd_ptr] : '0;
    assign FetchPC          = FetchValid ? q_pc[rd_ptr]    : '0;

endmodule
